// File: rtl/axis_flit_serializer.sv
// Splits each AXIS beat into SERIALIZATION_FACTOR flits and drives a credit-based router port.
// Latency: first flit one cycle after accept; beats stream back-to-back at SERIALIZATION_FACTOR cycles each.
// Backpressure: flits stall in place at zero credit; axis_tready opens only when the holding register frees.
module axis_flit_serializer #(
    parameter int TDATA_WIDTH          = 32,
    parameter int DEST_WIDTH           = 4,
    parameter int SERIALIZATION_FACTOR = 4,
    parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
    parameter int FLIT_BUFFER_DEPTH    = 8,
    parameter int CREDIT_WIDTH         = $clog2(FLIT_BUFFER_DEPTH + 1),
    parameter bit LSB_FIRST            = 1'b1
) (
    input  logic                    clk_noc,
    input  logic                    rst_noc_sync,
    input  logic                    axis_tvalid,
    output logic                    axis_tready,
    input  logic [TDATA_WIDTH-1:0]  axis_tdata,
    input  logic                    axis_tlast,
    input  logic [DEST_WIDTH-1:0]   axis_tdest,
    output logic [FLIT_WIDTH-1:0]   data_out,
    output logic [DEST_WIDTH-1:0]   dest_out,
    output logic                    is_tail_out,
    output logic                    send_out,
    input  logic                    credit_in,
    output logic [CREDIT_WIDTH-1:0] credits_avail,
    output logic                    credit_err
);

    localparam int IDX_WIDTH = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
    localparam logic [IDX_WIDTH-1:0]    LAST_IDX   = IDX_WIDTH'(SERIALIZATION_FACTOR - 1);
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

    logic                                          hold_valid;
    logic [SERIALIZATION_FACTOR-1:0][FLIT_WIDTH-1:0] hold_data;
    logic [DEST_WIDTH-1:0]                         hold_dest;
    logic                                          hold_last;
    logic [IDX_WIDTH-1:0]                          flit_idx;
    logic [IDX_WIDTH-1:0]                          slice_idx;
    logic [CREDIT_WIDTH-1:0]                       credit_cnt;
    logic                                          last_flit;
    logic                                          accept;

    assign last_flit     = (flit_idx == LAST_IDX);
    assign send_out      = hold_valid & (credit_cnt != '0) & ~rst_noc_sync;
    assign axis_tready   = ~rst_noc_sync & (~hold_valid | (send_out & last_flit));
    assign accept        = axis_tvalid & axis_tready;
    assign is_tail_out   = send_out & hold_last & last_flit;
    assign slice_idx     = LSB_FIRST ? flit_idx : (LAST_IDX - flit_idx);
    assign data_out      = hold_data[slice_idx];
    assign dest_out      = hold_dest;
    assign credits_avail = credit_cnt;

    // A load on the last flit's cycle overrides the clear, so beats stream without a bubble.
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            hold_valid <= 1'b0;
            flit_idx   <= '0;
        end else if (accept) begin
            hold_valid <= 1'b1;
            hold_data  <= axis_tdata;
            hold_dest  <= axis_tdest;
            hold_last  <= axis_tlast;
            flit_idx   <= '0;
        end else if (send_out) begin
            if (last_flit) begin
                hold_valid <= 1'b0;
                flit_idx   <= '0;
            end else begin
                flit_idx <= flit_idx + IDX_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            credit_cnt <= CREDIT_MAX;
            credit_err <= 1'b0;
        end else if (send_out && !credit_in) begin
            credit_cnt <= credit_cnt - CREDIT_WIDTH'(1);
        end else if (!send_out && credit_in) begin
            // A return beyond the buffer depth means downstream lost track; saturate and flag.
            if (credit_cnt == CREDIT_MAX) begin
                credit_err <= 1'b1;
            end else begin
                credit_cnt <= credit_cnt + CREDIT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_flit_serializer.sv
// Directed bench: default, MSB-first and shallow-credit instances share one stimulus stream.
module tb_axis_flit_serializer;

    logic        clk;
    logic        rst;
    logic        tvalid;
    logic [31:0] tdata;
    logic        tlast;
    logic [3:0]  tdest;
    logic        credit_in;

    logic       a_tready, a_tail, a_send, a_err;
    logic [7:0] a_data;
    logic [3:0] a_dest;
    logic [3:0] a_credits;

    logic       b_tready, b_tail, b_send, b_err;
    logic [7:0] b_data;
    logic [3:0] b_dest;
    logic [3:0] b_credits;

    logic       c_tready, c_tail, c_send, c_err;
    logic [7:0] c_data;
    logic [3:0] c_dest;
    logic [1:0] c_credits;

    int checks   = 0;
    int failures = 0;

    axis_flit_serializer dut_a (
        .clk_noc(clk), .rst_noc_sync(rst),
        .axis_tvalid(tvalid), .axis_tready(a_tready), .axis_tdata(tdata),
        .axis_tlast(tlast), .axis_tdest(tdest),
        .data_out(a_data), .dest_out(a_dest), .is_tail_out(a_tail), .send_out(a_send),
        .credit_in(credit_in), .credits_avail(a_credits), .credit_err(a_err)
    );

    axis_flit_serializer #(.LSB_FIRST(1'b0)) dut_b (
        .clk_noc(clk), .rst_noc_sync(rst),
        .axis_tvalid(tvalid), .axis_tready(b_tready), .axis_tdata(tdata),
        .axis_tlast(tlast), .axis_tdest(tdest),
        .data_out(b_data), .dest_out(b_dest), .is_tail_out(b_tail), .send_out(b_send),
        .credit_in(credit_in), .credits_avail(b_credits), .credit_err(b_err)
    );

    axis_flit_serializer #(.FLIT_BUFFER_DEPTH(2)) dut_c (
        .clk_noc(clk), .rst_noc_sync(rst),
        .axis_tvalid(tvalid), .axis_tready(c_tready), .axis_tdata(tdata),
        .axis_tlast(tlast), .axis_tdest(tdest),
        .data_out(c_data), .dest_out(c_dest), .is_tail_out(c_tail), .send_out(c_send),
        .credit_in(credit_in), .credits_avail(c_credits), .credit_err(c_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic l, input logic [3:0] dst);
        tvalid = 1'b1;
        tdata  = d;
        tlast  = l;
        tdest  = dst;
    endtask

    logic [7:0] exp_lsb [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [7:0] exp_msb [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    logic [7:0] exp_c   [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hCC};

    initial begin
        rst       = 1'b1;
        tvalid    = 1'b0;
        tdata     = '0;
        tlast     = 1'b0;
        tdest     = '0;
        credit_in = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_tready", a_tready, 1'b0);
        chk("rst_send", a_send, 1'b0);
        chk("rst_tail", a_tail, 1'b0);
        chk("rst_credits", a_credits, 4'd8);
        chk("rst_err", a_err, 1'b0);
        rst = 1'b0;
        tick();
        chk("idle_tready", a_tready, 1'b1);
        chk("idle_send", a_send, 1'b0);

        // LSB-first, MSB-first and two-credit instances on the same beat
        drive_beat(32'hDDCCBBAA, 1'b1, 4'h5);
        tick();
        tvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("a_send%0d", i), a_send, 1'b1);
            chk($sformatf("a_data%0d", i), a_data, exp_lsb[i]);
            chk($sformatf("a_dest%0d", i), a_dest, 4'h5);
            chk($sformatf("a_tail%0d", i), a_tail, (i == 3));
            chk($sformatf("a_tready%0d", i), a_tready, (i == 3));
            chk($sformatf("b_data%0d", i), b_data, exp_msb[i]);
            chk($sformatf("b_tail%0d", i), b_tail, (i == 3));
            chk($sformatf("c_send%0d", i), c_send, (i < 2));
            chk($sformatf("c_data%0d", i), c_data, exp_c[i]);
            chk($sformatf("c_tready%0d", i), c_tready, 1'b0);
            tick();
        end
        chk("a_send_done", a_send, 1'b0);
        chk("a_credits_4", a_credits, 4'd4);
        chk("c_starved_send", c_send, 1'b0);
        chk("c_starved_data", c_data, 8'hCC);
        chk("c_starved_credits", c_credits, 2'd0);
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        chk("c_regain_send", c_send, 1'b1);
        chk("c_regain_data", c_data, 8'hCC);
        chk("c_regain_tail", c_tail, 1'b0);
        tick();
        chk("c_restall_send", c_send, 1'b0);
        chk("c_restall_data", c_data, 8'hDD);
        chk("c_restall_credits", c_credits, 2'd0);
        chk("a_credits_5", a_credits, 4'd5);

        // Three back-to-back beats, credit returned one cycle after each send
        do_reset();
        begin
            int  beat;
            logic prev_send;
            logic hs;
            logic [31:0] beats [3] = '{32'h03020100, 32'h07060504, 32'h0B0A0908};
            beat      = 0;
            prev_send = 1'b0;
            drive_beat(beats[0], 1'b0, 4'h3);
            for (int k = 0; k < 15; k++) begin
                hs = tvalid & a_tready;
                chk($sformatf("s_hs%0d", k), hs, (k == 0 || k == 4 || k == 8));
                chk($sformatf("s_send%0d", k), a_send, (k >= 1 && k <= 12));
                chk($sformatf("s_tail%0d", k), a_tail, (k == 12));
                if (k >= 1 && k <= 12)
                    chk($sformatf("s_data%0d", k), a_data, 8'(k - 1));
                if (k == 14)
                    chk("s_credits_end", a_credits, 4'd8);
                credit_in = prev_send;
                prev_send = a_send;
                tick();
                if (hs) begin
                    beat++;
                    if (beat < 3) drive_beat(beats[beat], (beat == 2), 4'h3);
                    else tvalid = 1'b0;
                end
            end
            credit_in = 1'b0;
            chk("s_err", a_err, 1'b0);
        end

        // Simultaneous send and return hold the count; overflow is sticky
        do_reset();
        drive_beat(32'h12345678, 1'b1, 4'h9);
        tick();
        tvalid    = 1'b0;
        credit_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("x_send%0d", i), a_send, 1'b1);
            chk($sformatf("x_credits%0d", i), a_credits, 4'd8);
            tick();
        end
        chk("x_pre_err", a_err, 1'b0);
        chk("x_pre_send", a_send, 1'b0);
        tick();
        credit_in = 1'b0;
        chk("x_ovf_credits", a_credits, 4'd8);
        chk("x_ovf_err", a_err, 1'b1);
        tick();
        tick();
        chk("x_err_sticky", a_err, 1'b1);

        // Reset in the middle of a beat
        drive_beat(32'hDDCCBBAA, 1'b1, 4'h5);
        tick();
        tvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("m_data%0d", i), a_data, exp_lsb[i]);
            if (i < 2) tick();
        end
        chk("m_credits_mid", a_credits, 4'd6);
        rst = 1'b1;
        tick();
        chk("m_rst_send", a_send, 1'b0);
        chk("m_rst_tready", a_tready, 1'b0);
        chk("m_rst_tail", a_tail, 1'b0);
        rst = 1'b0;
        tick();
        chk("m_post_credits", a_credits, 4'd8);
        chk("m_post_err", a_err, 1'b0);
        chk("m_post_send", a_send, 1'b0);
        drive_beat(32'h44332211, 1'b0, 4'h2);
        tick();
        tvalid = 1'b0;
        chk("m_new_send", a_send, 1'b1);
        chk("m_new_data", a_data, 8'h11);
        chk("m_new_dest", a_dest, 4'h2);
        tick();
        chk("m_new_data1", a_data, 8'h22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
